// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: registered word after WAIT_CYCLES wait states (erroneous fetch: 1 cycle).
// No backpressure input; stall_req is raised toward the pipeline while a fetch sits in WAIT.
module inst_mem_resp #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [31:0]       addr,
   output logic [31:0]       inst,
   output logic              inst_valid,
   output logic              addr_err,
   output logic              stall_req,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] rd_idx;
   logic              accept;
   logic              fetch_err;
   logic              err_nxt;
   logic [31:0]       mem [2**ADDR_W];

   assign fetch_err = (addr[1:0] != 2'b00) || (|addr[31:ADDR_W+2]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         WAIT: begin
            if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         default: begin
            // IDLE and RESP both accept; RESP falls back to IDLE when ce is low
            state_nxt = IDLE;
            if (ce) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0 || fetch_err) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = WAIT_LOAD;
               end
            end
         end
      endcase
   end

   // a response out of WAIT always uses the captured index and is never erroneous
   assign rd_idx  = (state == WAIT) ? idx_q : addr[ADDR_W+1:2];
   assign err_nxt = (state != WAIT) && fetch_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= '0;
         inst     <= 32'h0000_0000;
         addr_err <= 1'b0;
      end else begin
         if (accept) idx_q <= addr[ADDR_W+1:2];
         if (state_nxt == RESP) begin
            inst     <= err_nxt ? NOP_WORD : mem[rd_idx];
            addr_err <= err_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_we) mem[load_addr] <= load_data;
   end

   assign inst_valid = (state == RESP);
   assign stall_req  = (state == WAIT);

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: two instances (0 and 3 wait states) share stimulus and are checked
// every cycle against a time-based reference model, plus a vector table and corner sequences.
module tb_inst_mem_resp;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst, ce, load_we;
   logic [31:0]       addr, load_data;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       inst0, inst3;
   logic              valid0, valid3, err0, err3, stall0, stall3;

   int checks = 0;
   int errors = 0;

   inst_mem_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0), .NOP_WORD(32'h0)) u_w0 (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr),
      .inst(inst0), .inst_valid(valid0), .addr_err(err0), .stall_req(stall0),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

   inst_mem_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3), .NOP_WORD(32'h0)) u_w3 (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr),
      .inst(inst3), .inst_valid(valid3), .addr_err(err3), .stall_req(stall3),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   // Reference model: each instance holds at most one pending fetch, answered at edge 'due'.
   int                cyc = 0;
   bit                pend    [2];
   int                due     [2];
   logic [ADDR_W-1:0] pidx    [2];
   bit                perr    [2];
   logic [31:0]       m_inst  [2];
   logic              m_err   [2];
   logic              m_valid [2];
   logic              m_stall [2];
   logic [31:0]       mmem    [1<<ADDR_W];

   function automatic int wait_of(input int m);
      return (m == 0) ? 0 : 3;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         pend[m]    = 1'b0;
         m_inst[m]  = 32'h0;
         m_err[m]   = 1'b0;
         m_valid[m] = 1'b0;
         m_stall[m] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit bad;
      cyc++;
      bad = (addr[1:0] != 2'b00) || (addr >= (32'd1 << (ADDR_W + 2)));
      if (rst) begin
         model_reset();
      end else begin
         for (int m = 0; m < 2; m++) begin
            if (ce && (!pend[m] || due[m] < cyc)) begin
               pend[m] = 1'b1;
               pidx[m] = addr[ADDR_W+1:2];
               perr[m] = bad;
               due[m]  = cyc + (bad ? 0 : wait_of(m));
            end
            m_valid[m] = pend[m] && (due[m] == cyc);
            m_stall[m] = pend[m] && (due[m] > cyc);
            if (m_valid[m]) begin
               m_inst[m] = perr[m] ? 32'h0 : mmem[pidx[m]];
               m_err[m]  = perr[m];
            end
         end
      end
      if (load_we) mmem[load_addr] = load_data;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      chk($sformatf("%s w0.inst_valid", tag), 32'(valid0), 32'(m_valid[0]));
      chk($sformatf("%s w0.stall_req", tag),  32'(stall0), 32'(m_stall[0]));
      chk($sformatf("%s w0.inst", tag),       inst0,       m_inst[0]);
      chk($sformatf("%s w0.addr_err", tag),   32'(err0),   32'(m_err[0]));
      chk($sformatf("%s w3.inst_valid", tag), 32'(valid3), 32'(m_valid[1]));
      chk($sformatf("%s w3.stall_req", tag),  32'(stall3), 32'(m_stall[1]));
      chk($sformatf("%s w3.inst", tag),       inst3,       m_inst[1]);
      chk($sformatf("%s w3.addr_err", tag),   32'(err3),   32'(m_err[1]));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all($sformatf("cyc%0d", cyc));
   endtask

   typedef struct {
      logic        ce;
      logic [31:0] addr;
      logic        v0; logic [31:0] i0; logic e0; logic s0;
      logic        v3; logic [31:0] i3; logic e3; logic s3;
   } vec_t;

   vec_t vec [12];

   initial begin
      rst = 1'b1; ce = 1'b0; addr = 32'h0;
      load_we = 1'b0; load_addr = '0; load_data = 32'h0;
      model_reset();

      //            ce    addr          v0    i0             e0    s0    v3    i3             e3    s3
      vec[0]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
      vec[1]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
      vec[2]  = '{1'b1, 32'h0000_0008, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
      vec[3]  = '{1'b1, 32'h0000_000C, 1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0};
      vec[4]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b0};
      vec[5]  = '{1'b1, 32'h0000_0008, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b1};
      vec[6]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b1};
      vec[7]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b1};
      vec[8]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0};
      vec[9]  = '{1'b1, 32'h0000_0006, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vec[10] = '{1'b1, 32'h0000_1000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vec[11] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

      // reset state
      step(); step();
      chk("reset w3.inst", inst3, 32'h0);
      chk("reset w0.inst_valid", 32'(valid0), 32'h0);
      rst = 1'b0;

      // preload indices 0..15
      for (int i = 0; i < 16; i++) begin
         load_we   = 1'b1;
         load_addr = ADDR_W'(i);
         load_data = (i < 4) ? 32'(i + 1) * 32'h1111_1111 : 32'hA500_0000 + 32'(i);
         step();
      end
      load_we = 1'b0;

      for (int i = 0; i < 12; i++) begin
         ce   = vec[i].ce;
         addr = vec[i].addr;
         step();
         chk($sformatf("vec%0d w0.valid", i), 32'(valid0), 32'(vec[i].v0));
         chk($sformatf("vec%0d w0.inst", i),  inst0,       vec[i].i0);
         chk($sformatf("vec%0d w0.err", i),   32'(err0),   32'(vec[i].e0));
         chk($sformatf("vec%0d w0.stall", i), 32'(stall0), 32'(vec[i].s0));
         chk($sformatf("vec%0d w3.valid", i), 32'(valid3), 32'(vec[i].v3));
         chk($sformatf("vec%0d w3.inst", i),  inst3,       vec[i].i3);
         chk($sformatf("vec%0d w3.err", i),   32'(err3),   32'(vec[i].e3));
         chk($sformatf("vec%0d w3.stall", i), 32'(stall3), 32'(vec[i].s3));
      end

      // read-before-write on the edge entering RESP
      ce = 1'b1; addr = 32'h8;
      step();
      ce = 1'b0;
      step(); step();
      load_we = 1'b1; load_addr = ADDR_W'(2); load_data = 32'hDEAD_BEEF;
      step();
      chk("rbw w3.valid", 32'(valid3), 32'h1);
      chk("rbw w3.old_data", inst3, 32'h3333_3333);
      load_we = 1'b0;
      ce = 1'b1; addr = 32'h8;
      step();
      chk("refetch w0.inst", inst0, 32'hDEAD_BEEF);
      ce = 1'b0;
      step(); step(); step();
      chk("refetch w3.valid", 32'(valid3), 32'h1);
      chk("refetch w3.inst", inst3, 32'hDEAD_BEEF);

      // asynchronous reset in the second wait cycle drops the fetch
      ce = 1'b1; addr = 32'hC;
      step();
      ce = 1'b0;
      step();
      chk("pre_rst w3.stall", 32'(stall3), 32'h1);
      rst = 1'b1;
      model_reset();
      #1;
      compare_all("async_rst");
      chk("async_rst w3.stall", 32'(stall3), 32'h0);
      chk("async_rst w3.inst", inst3, 32'h0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("post_rst%0d w3.valid", i), 32'(valid3), 32'h0);
      end
      ce = 1'b1; addr = 32'h4;
      step();
      ce = 1'b0;
      step(); step(); step();
      chk("post_rst w3.data", inst3, 32'h2222_2222);

      // reset release with ce already high accepts on the first edge
      rst = 1'b1;
      model_reset();
      ce = 1'b1; addr = 32'h0;
      step();
      rst = 1'b0;
      step();
      chk("release w0.valid", 32'(valid0), 32'h1);
      chk("release w0.inst", inst0, 32'h1111_1111);
      ce = 1'b0;
      step(); step(); step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         int unsigned mode, idx;
         mode = $urandom_range(0, 9);
         idx  = $urandom_range(0, 15);
         ce   = ($urandom_range(0, 9) < 6);
         if (mode < 6)      addr = idx << 2;
         else if (mode < 8) addr = (idx << 2) | $urandom_range(1, 3);
         else               addr = ($urandom_range(1, 1048575) << 12) | (idx << 2);
         load_we   = ($urandom_range(0, 4) == 0);
         load_addr = ADDR_W'($urandom_range(0, 15));
         load_data = $urandom;
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            model_reset();
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
